// File: rtl/piezo_alert_qual_pkg.sv
// Shared types and default constants for the piezo alert qualifier.
package piezo_alert_pkg;

   localparam int SAMPLE_W = 12;
   localparam int CNT_W    = 8;
   localparam int TMR_W    = 25;

   localparam logic [SAMPLE_W-1:0] BATT_THR_DEF  = 12'h900;
   localparam logic [SAMPLE_W-1:0] BATT_HYST_DEF = 12'h080;
   localparam logic [SAMPLE_W-1:0] SPD_THR_DEF   = 12'h600;
   localparam int unsigned         PERSIST_DEF   = 8;
   localparam logic [TMR_W-1:0]    OVR_HOLD_DEF  = 25'd25_000_000;

   typedef enum logic {B_OK, B_LOW} batt_state_t;
   typedef enum logic [1:0] {S_OK, S_OVR, S_HOLD} spd_state_t;

endpackage

// File: rtl/piezo_alert_qual_persist_cnt.sv
// Saturating consecutive-sample counter; hit flags the strobe that completes the run.
module persist_cnt
   import piezo_alert_pkg::*;
#(
   parameter int unsigned PERSIST = PERSIST_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld,
   input  logic qual,
   input  logic clr,
   output logic hit
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERSIST - 1);

   logic [CNT_W-1:0] cnt;

   assign hit = vld & qual & ~clr & (cnt == LAST);

   // The run restarts after a hit so the next state begins counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (vld) begin
         if (!qual || hit)
            cnt <= '0;
         else if (cnt != {CNT_W{1'b1}})
            cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/piezo_alert_qual.sv
// Qualifies battery and motor-speed samples into clean piezo mode requests.
// Optional build macro PIEZO_BATT_LATCH_EN makes the low-battery alert terminal until reset.
module piezo_alert_qual
   import piezo_alert_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] BATT_THR  = BATT_THR_DEF,
   parameter logic [SAMPLE_W-1:0] BATT_HYST = BATT_HYST_DEF,
   parameter logic [SAMPLE_W-1:0] SPD_THR   = SPD_THR_DEF,
   parameter int unsigned         PERSIST   = PERSIST_DEF,
   parameter logic [TMR_W-1:0]    OVR_HOLD  = OVR_HOLD_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SAMPLE_W-1:0]        batt,
   input  logic                       batt_vld,
   input  logic signed [SAMPLE_W-1:0] lft_spd,
   input  logic signed [SAMPLE_W-1:0] rght_spd,
   input  logic                       spd_vld,
   input  logic                       pwr_up,
   input  logic                       en_steer,
   output logic                       norm_mode,
   output logic                       ovr_spd,
   output logic                       batt_low
);

   localparam logic [TMR_W-1:0] HOLD_M1 = OVR_HOLD - 25'd1;

   // -2048 has no positive twin in 12 bits, so it saturates to 2047.
   function automatic logic [SAMPLE_W-1:0] sat_mag(input logic signed [SAMPLE_W-1:0] x);
      if (!x[SAMPLE_W-1])
         return $unsigned(x);
      else if (x == $signed(12'h800))
         return 12'h7FF;
      else
         return $unsigned(-x);
   endfunction

   batt_state_t b_state;
   logic        b_qual, b_clr, b_hit;
   logic        batt_under;

   assign batt_under = (batt < BATT_THR);

`ifdef PIEZO_BATT_LATCH_EN
   assign b_qual = batt_under;
   assign b_clr  = (b_state == B_LOW);
`else
   // Release level kept in 13 bits; above 4095 it is simply unreachable.
   localparam logic [SAMPLE_W:0] BATT_REL = {1'b0, BATT_THR} + {1'b0, BATT_HYST};
   assign b_qual = (b_state == B_OK) ? batt_under : ({1'b0, batt} >= BATT_REL);
   assign b_clr  = 1'b0;
`endif

   persist_cnt #(.PERSIST(PERSIST)) u_batt_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .vld  (batt_vld),
      .qual (b_qual),
      .clr  (b_clr),
      .hit  (b_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_state  <= B_OK;
         batt_low <= 1'b0;
      end else begin
         case (b_state)
            B_OK: if (b_hit) begin
               b_state  <= B_LOW;
               batt_low <= 1'b1;
            end
            B_LOW: begin
`ifndef PIEZO_BATT_LATCH_EN
               if (b_hit) begin
                  b_state  <= B_OK;
                  batt_low <= 1'b0;
               end
`endif
            end
            default: begin
               b_state  <= B_OK;
               batt_low <= 1'b0;
            end
         endcase
      end
   end

   spd_state_t          s_state;
   logic [TMR_W-1:0]    tmr;
   logic [SAMPLE_W-1:0] lft_mag, rght_mag, spd_max;
   logic                s_qual, s_rel, s_clr, s_hit;

   assign lft_mag  = sat_mag(lft_spd);
   assign rght_mag = sat_mag(rght_spd);
   assign spd_max  = (lft_mag > rght_mag) ? lft_mag : rght_mag;
   assign s_qual   = (spd_max > SPD_THR);
   assign s_rel    = spd_vld & s_qual;
   assign s_clr    = (s_state != S_OK);

   persist_cnt #(.PERSIST(PERSIST)) u_spd_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .vld  (spd_vld),
      .qual (s_qual),
      .clr  (s_clr),
      .hit  (s_hit)
   );

   // A qualifying sample takes priority over timer expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_state <= S_OK;
         tmr     <= '0;
         ovr_spd <= 1'b0;
      end else begin
         case (s_state)
            S_OK: if (s_hit) begin
               s_state <= S_OVR;
               tmr     <= HOLD_M1;
               ovr_spd <= 1'b1;
            end
            S_OVR: begin
               if (s_rel)
                  tmr <= HOLD_M1;
               else if (tmr == '0)
                  s_state <= S_HOLD;
               else
                  tmr <= tmr - 25'd1;
            end
            S_HOLD: begin
               if (s_rel) begin
                  s_state <= S_OVR;
                  tmr     <= HOLD_M1;
               end else if (spd_vld) begin
                  s_state <= S_OK;
                  ovr_spd <= 1'b0;
               end
            end
            default: begin
               s_state <= S_OK;
               ovr_spd <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         norm_mode <= 1'b0;
      else
         norm_mode <= pwr_up & en_steer;
   end

endmodule

// File: tb/tb_piezo_alert_qual.sv
// Self-checking bench for piezo_alert_qual: vector table plus hold-timer and reset sequences.
module tb_piezo_alert_qual;
   import piezo_alert_pkg::*;

   localparam int H = 1000;
`ifdef PIEZO_BATT_LATCH_EN
   localparam logic BL = 1'b1;
`else
   localparam logic BL = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [11:0]        batt = '0;
   logic               batt_vld = 1'b0;
   logic signed [11:0] lft_spd = '0;
   logic signed [11:0] rght_spd = '0;
   logic               spd_vld = 1'b0;
   logic               pwr_up = 1'b0;
   logic               en_steer = 1'b0;
   logic               norm_mode, ovr_spd, batt_low;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] batt;
      logic        bv;
      logic [11:0] lft;
      logic [11:0] rght;
      logic        sv;
      logic        pu;
      logic        es;
      logic [2:0]  expd;   // {norm_mode, ovr_spd, batt_low}
   } vec_t;

   vec_t       vecs[$];
   logic [2:0] exp_q[$];

   piezo_alert_qual #(
      .BATT_THR (12'h900),
      .BATT_HYST(12'h080),
      .SPD_THR  (12'h600),
      .PERSIST  (8),
      .OVR_HOLD (25'd1000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .batt     (batt),
      .batt_vld (batt_vld),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .spd_vld  (spd_vld),
      .pwr_up   (pwr_up),
      .en_steer (en_steer),
      .norm_mode(norm_mode),
      .ovr_spd  (ovr_spd),
      .batt_low (batt_low)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got {norm,ovr,blow}=%b expected %b at %0t", nm, act, req, $time);
      end
   endtask

   function automatic vec_t mkv(input logic [11:0] b, input logic bv, input logic [11:0] l,
                                input logic [11:0] r, input logic sv, input logic pu,
                                input logic es, input logic [2:0] e);
      vec_t v;
      v.batt = b; v.bv = bv; v.lft = l; v.rght = r; v.sv = sv; v.pu = pu; v.es = es; v.expd = e;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string nm);
      @(negedge clk);
      batt = v.batt; batt_vld = v.bv;
      lft_spd = $signed(v.lft); rght_spd = $signed(v.rght); spd_vld = v.sv;
      pwr_up = v.pu; en_steer = v.es;
      exp_q.push_back(v.expd);
      @(posedge clk);
      #1;
      chk(nm, {norm_mode, ovr_spd, batt_low}, exp_q.pop_front());
   endtask

   // n copies: all but the last expect mid, the last expects last.
   task automatic add_run(input int n, input vec_t v, input logic [2:0] mid, input logic [2:0] last);
      for (int i = 0; i < n; i++) begin
         v.expd = (i == n - 1) ? last : mid;
         vecs.push_back(v);
      end
   endtask

   task automatic run(input int n, input string nm, input vec_t v,
                      input logic [2:0] mid, input logic [2:0] last);
      for (int i = 0; i < n; i++) begin
         v.expd = (i == n - 1) ? last : mid;
         apply(v, nm);
      end
   endtask

   initial begin
      vec_t idle, slow, fast;
      idle = mkv(12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 3'b000);
      slow = mkv(12'h000, 0, 12'h000, 12'h000, 1, 0, 0, 3'b000);
      fast = mkv(12'h000, 0, 12'h900, 12'h000, 1, 0, 0, 3'b000);

      // Reset and idle
      repeat (3) @(negedge clk);
      #1 chk("reset_hold", {norm_mode, ovr_spd, batt_low}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1 chk("idle_100", {norm_mode, ovr_spd, batt_low}, 3'b000);

      // Vector table
      add_run(1, mkv(12'h000, 0, 12'h000, 12'h000, 0, 1, 1, 0), 3'b100, 3'b100);
      add_run(1, mkv(12'h000, 0, 12'h000, 12'h000, 0, 0, 1, 0), 3'b000, 3'b000);
      add_run(7, mkv(12'h800, 1, 12'h000, 12'h000, 0, 0, 0, 0), 3'b000, 3'b000);
      add_run(1, mkv(12'hA00, 1, 12'h000, 12'h000, 0, 0, 0, 0), 3'b000, 3'b000);
      add_run(4, mkv(12'h800, 1, 12'h000, 12'h000, 0, 0, 0, 0), 3'b000, 3'b000);
      add_run(5, mkv(12'hA00, 0, 12'h000, 12'h000, 0, 0, 0, 0), 3'b000, 3'b000);
      add_run(4, mkv(12'h800, 1, 12'h000, 12'h000, 0, 0, 0, 0), 3'b000, 3'b001);
      add_run(8, mkv(12'h950, 1, 12'h000, 12'h000, 0, 0, 0, 0), 3'b001, 3'b001);
      add_run(8, mkv(12'h980, 1, 12'h000, 12'h000, 0, 0, 0, 0), 3'b001, {2'b00, BL});
      add_run(8, mkv(12'h000, 0, 12'h600, 12'hA00, 1, 0, 0, 0), {2'b00, BL}, {2'b00, BL});
      add_run(7, mkv(12'h000, 0, 12'h900, 12'h000, 1, 0, 0, 0), {2'b00, BL}, {2'b00, BL});
      add_run(1, mkv(12'h000, 0, 12'h5FF, 12'h000, 1, 0, 0, 0), {2'b00, BL}, {2'b00, BL});
      add_run(8, mkv(12'hA00, 1, 12'h800, 12'h000, 1, 0, 0, 0), {2'b00, BL}, {2'b01, BL});
      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("vec%0d", i));

      // Hold timer: ovr_spd lasts exactly H clocks in S_OVR, then S_HOLD
      run(H - 1, "hold_quiet", idle, {2'b01, BL}, {2'b01, BL});
      run(1, "hold_edge", slow, {2'b01, BL}, {2'b01, BL});
      run(1, "hold_drop", slow, {2'b00, BL}, {2'b00, BL});

      // Reload from a qualifying sample mid-hold
      fast.rght = 12'h900; fast.lft = 12'h000;
      run(8, "burst2", fast, {2'b00, BL}, {2'b01, BL});
      run(499, "reload_pre", idle, {2'b01, BL}, {2'b01, BL});
      run(1, "reload", fast, {2'b01, BL}, {2'b01, BL});
      run(H - 1, "reload_quiet", idle, {2'b01, BL}, {2'b01, BL});
      run(1, "reload_edge", slow, {2'b01, BL}, {2'b01, BL});
      run(1, "reload_drop", slow, {2'b00, BL}, {2'b00, BL});

      // Asynchronous reset mid-burst with every output high
      run(8, "pre_rst", mkv(12'h800, 1, 12'h900, 12'h000, 1, 1, 1, 0), {2'b10, BL}, 3'b111);
      run(3, "pre_rst_hi", mkv(12'h800, 1, 12'h900, 12'h000, 1, 1, 1, 0), 3'b111, 3'b111);
      #3 rst_n = 1'b0;
      #1 chk("async_rst", {norm_mode, ovr_spd, batt_low}, 3'b000);
      @(negedge clk);
      pwr_up = 1'b0; en_steer = 1'b0; spd_vld = 1'b0; batt_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run(8, "post_rst", mkv(12'h800, 1, 12'h900, 12'h000, 1, 0, 0, 0), 3'b000, 3'b011);

      if (exp_q.size() != 0)
         chk("queue_drain", 3'(exp_q.size()), 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piezo_alert_qual.md
# piezo_alert_qual

Alert qualifier that sits directly upstream of the piezo driver and produces its three mode inputs: `norm_mode`, `ovr_spd` and `batt_low`. It filters raw battery A2D samples and signed motor-speed samples with persistence counters and hysteresis, so the piezo sees clean, glitch-free requests. `ovr_spd` is stretched to a minimum on-time so a short over-speed event is still audible. All outputs are registered, and the block runs in the single system clock domain.

## Interface
Parameters:
- `BATT_THR`, 12'h900: battery-low entry threshold (unsigned counts).
- `BATT_HYST`, 12'h080: release hysteresis; the release level is `BATT_THR + BATT_HYST`.
- `SPD_THR`, 12'h600: over-speed magnitude threshold.
- `PERSIST`, 8: consecutive qualifying samples required to change an alert state (range 1..255).
- `OVR_HOLD`, 25'd25_000_000: minimum `ovr_spd` high time in clocks (0.5 s at 50 MHz).

Ports:
- `clk`, input, 1: system clock. One clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `batt`, input, 12: battery A2D reading, unsigned.
- `batt_vld`, input, 1: one-cycle strobe; `batt` is valid in that cycle.
- `lft_spd`, input, 12: left motor speed, signed two's complement.
- `rght_spd`, input, 12: right motor speed, signed two's complement.
- `spd_vld`, input, 1: one-cycle strobe; both speed inputs are valid in that cycle.
- `pwr_up`, input, 1: rider power-up request.
- `en_steer`, input, 1: steering enabled (rider on board).
- `norm_mode`, output, 1: normal-operation tone request.
- `ovr_spd`, output, 1: over-speed alert.
- `batt_low`, output, 1: low-battery alert.

## Operation
- **Reset values:** all outputs are 0; both persistence counters are 0; the hold timer is 0; both FSMs are in their OK state.
- **Battery FSM, states `B_OK` and `B_LOW`.** The FSM only acts on cycles where `batt_vld` is high.
  - In `B_OK`: a sample with `batt < BATT_THR` increments the counter; any other sample clears it. When the count reaches `PERSIST`, go to `B_LOW` and clear the counter.
  - In `B_LOW`: a sample with `batt >= BATT_THR + BATT_HYST` increments the counter; any other sample clears it. When the count reaches `PERSIST`, go to `B_OK`.
  - Compute the release level in 13 bits so it cannot wrap. If the level exceeds 4095, the FSM never releases.
- **Speed FSM, states `S_OK`, `S_OVR` and `S_HOLD`.**
  - Magnitude: `|x|` is computed per side, saturating -2048 to 2047. The sample qualifies when `max(|lft|,|rght|) > SPD_THR`.
  - In `S_OK`: the FSM counts consecutive qualifying `spd_vld` samples. When the count reaches `PERSIST`, go to `S_OVR` and load the timer with `OVR_HOLD-1`.
  - In `S_OVR`: the timer decrements every clock. A qualifying sample reloads the timer. When the timer reaches 0, go to `S_HOLD`.
  - In `S_HOLD`: a qualifying sample returns to `S_OVR` with a reload. One non-qualifying sample returns to `S_OK`.
  - `ovr_spd` is 1 in `S_OVR` and `S_HOLD`.
- **`norm_mode`:** registered `pwr_up & en_steer`. It is independent of the alerts; tone priority is resolved downstream.
- **Reset mid-operation:** reset immediately clears all state and outputs (asynchronous).

## Timing
- Alert outputs have 1-cycle latency: they update on the same rising edge that samples the `PERSIST`-th qualifying strobe, and are visible in the following cycle.
- `norm_mode` is exactly 1 cycle behind `pwr_up & en_steer`.
- Cycles without a strobe never change counters. The gap between strobes is unbounded.
- `batt_vld` and `spd_vld` may be high in the same cycle; each is handled independently.
- If a qualifying sample arrives in the same cycle the timer reaches 0, the reload wins and the FSM stays in `S_OVR`.
- Minimum `ovr_spd` pulse is `OVR_HOLD` clocks measured from the asserting edge.

## Configuration
- `PIEZO_BATT_LATCH_EN` defined: `B_LOW` is terminal, so `batt_low` stays high until `rst_n` is asserted. The release comparison and counter path are not built.
- `PIEZO_BATT_LATCH_EN` not defined: hysteresis release as described in Operation.

## Structure
- Package `piezo_alert_pkg` holds:
  - the `batt_state_t` and `spd_state_t` enums;
  - the default threshold, hysteresis, persist and hold constants;
  - `SAMPLE_W = 12`.
- Sub-module `persist_cnt` is a saturating consecutive-sample counter with `vld`, `qual` and `clr` inputs and a `hit` output. It is instantiated twice, once for battery and once for speed.

## Test plan
All scenarios use `PERSIST=8`, with `OVR_HOLD=1000` set for simulation.
- Reset, then idle for 100 clocks -> all outputs are 0. Drive `pwr_up=1` and `en_steer=1` -> `norm_mode`=1 one cycle later.
- 7 battery samples of 12'h800 followed by one 12'hA00 -> `batt_low` stays 0. Then 8 consecutive 12'h800 samples -> `batt_low`=1 after the 8th strobe.
- While `batt_low`: 8 samples of 12'h950 (between 12'h900 and the 12'h980 release level) -> `batt_low` stays 1. Then 8 samples of 12'h980 -> `batt_low`=0, or stays 1 when `PIEZO_BATT_LATCH_EN` is defined.
- Edge cases for speed:
  - 8 samples of `lft_spd`=-12'sh700 -> `ovr_spd`=1.
  - 8 samples with `lft_spd` = -2048 (12'h800) -> qualifies, since its magnitude saturates to 2047.
  - 8 samples at 12'h600 exactly -> no alert.
- Single 8-sample burst over `SPD_THR`, then quiet -> `ovr_spd` high for exactly 1000 clocks and stays high into `S_HOLD`. The next slow sample -> `ovr_spd` drops.
- Assert `rst_n`=0 mid-burst with `batt_low`=1 and `ovr_spd`=1 -> all outputs go to 0 immediately, and the counters restart from 0 after release.
